// File: rtl/delay_and_sum_sdiv_seq.sv
// Iterative restoring signed divider: one quotient bit per enabled cycle, valid/ready on both
// sides, global clock enable freezes all state.
module delay_and_sum_sdiv_seq #(
  parameter int unsigned ID         = 1,
  parameter int unsigned din0_WIDTH = 73,
  parameter int unsigned din1_WIDTH = 11,
  parameter int unsigned dout_WIDTH = 73
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_zero
);
  localparam int unsigned W0 = din0_WIDTH;
  localparam int unsigned W1 = din1_WIDTH;
  localparam int unsigned CW = $clog2(W0 + 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [CW-1:0] CntLoad = CW'(W0);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W0-1:0]   dvd_q, dvd_d;    // dividend bits shift out, quotient bits shift in
  logic [W1-1:0]   dabs_q, dabs_d;
  logic [W1:0]     part_q, part_d;
  logic            sign_q_q, sign_q_d;
  logic            sign_r_q, sign_r_d;
  logic            dz_q, dz_d;
  logic [W0-1:0]   quot_q, quot_d;
  logic [W1-1:0]   rem_q, rem_d;
  logic            div_zero_q, div_zero_d;

  logic [W1:0]     shifted;
  logic [W1+1:0]   trial;

  assign shifted = {part_q[W1-1:0], dvd_q[W0-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dabs_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dabs_d     = dabs_q;
    part_d     = part_q;
    sign_q_d   = sign_q_q;
    sign_r_d   = sign_r_q;
    dz_d       = dz_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    if (ce) begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            // Magnitudes are unsigned, so the most-negative operand cannot overflow.
            dvd_d    = din0[W0-1] ? -din0 : din0;
            dabs_d   = din1[W1-1] ? -din1 : din1;
            sign_q_d = din0[W0-1] ^ din1[W1-1];
            sign_r_d = din0[W0-1];
            dz_d     = (din1 == '0);
            part_d   = '0;
            cnt_d    = CntLoad;
            state_d  = StCalc;
          end
        end
        StCalc: begin
          part_d = trial[W1+1] ? shifted : trial[W1:0];
          dvd_d  = {dvd_q[W0-2:0], ~trial[W1+1]};
          cnt_d  = cnt_q - CntOne;
          if (cnt_q == CntOne) state_d = StFix;
        end
        StFix: begin
          quot_d     = dz_q ? '0 : (sign_q_q ? -dvd_q : dvd_q);
          rem_d      = dz_q ? '0 : (sign_r_q ? -part_q[W1-1:0] : part_q[W1-1:0]);
          div_zero_d = dz_q;
          state_d    = StDone;
        end
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dabs_q     <= '0;
      part_q     <= '0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      dz_q       <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dabs_q     <= dabs_d;
      part_q     <= part_d;
      sign_q_q   <= sign_q_d;
      sign_r_q   <= sign_r_d;
      dz_q       <= dz_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign in_ready  = ce && (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_delay_and_sum_sdiv_seq.sv
// Bench for delay_and_sum_sdiv_seq: vector table, latency/stall/reset sequences and random ops,
// all checked through a result scoreboard.
module tb_delay_and_sum_sdiv_seq;
  localparam int W0 = 73;
  localparam int W1 = 11;

  logic          clk = 1'b0;
  logic          reset, ce, in_valid, in_ready, out_valid, out_ready, div_zero;
  logic [W0-1:0] din0, quot;
  logic [W1-1:0] din1, rem;

  delay_and_sum_sdiv_seq #(.ID(1), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(W0)) dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W0-1:0] a;
    logic [W1-1:0] b;
    logic [W0-1:0] q;
    logic [W1-1:0] r;
    logic          dz;
  } vec_t;

  vec_t tbl[14];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [W0-1:0] most_neg;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [W0-1:0] a, input logic [W1-1:0] b);
    vec_t v;
    logic signed [W0-1:0] sa, sq, sr;
    logic signed [W1-1:0] sbv;
    sa = a;
    sbv = b;
    v.a = a; v.b = b; v.dz = 1'b0;
    if (b == '0) begin
      v.q = '0; v.r = '0; v.dz = 1'b1;
    end else if (a == {1'b1, {(W0-1){1'b0}}} && sbv == -1) begin
      v.q = a; v.r = '0;
    end else begin
      sq = sa / sbv;
      sr = sa % sbv;
      v.q = sq;
      v.r = sr[W1-1:0];
    end
    return v;
  endfunction

  // Compare on the falling edge of the cycle in which the result is consumed.
  always @(negedge clk) begin
    if (!reset && ce && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 128'(out_valid), 128'(0));
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk("quot", 128'(quot), 128'(e.q));
        chk("rem", 128'(rem), 128'(e.r));
        chk("div_zero", 128'(div_zero), 128'(e.dz));
      end
    end
  end

  // Presents operands until accepted; returns just after the accepting edge.
  task automatic send(input vec_t e);
    bit ok = 0;
    din0 = e.a; din1 = e.b; in_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic drain();
    int i = 0;
    while (sb.size() != 0 && i < 400) begin
      @(posedge clk); #1;
      i++;
    end
    if (sb.size() != 0) begin
      chk("result_timeout", 128'(sb.size()), 128'(0));
      sb.delete();
    end
  endtask

  initial begin
    vec_t v;
    int   n;
    logic [W0-1:0] q_hold;
    logic [W1-1:0] r_hold;
    logic [W1-1:0] specials[5];

    most_neg = {1'b1, {(W0-1){1'b0}}};
    tbl[0]  = '{73'sd100,   11'sd7,     73'sd14,   11'sd2,    1'b0};
    tbl[1]  = '{-73'sd100,  11'sd7,     -73'sd14,  -11'sd2,   1'b0};
    tbl[2]  = '{73'sd100,   -11'sd7,    -73'sd14,  11'sd2,    1'b0};
    tbl[3]  = '{-73'sd100,  -11'sd7,    73'sd14,   -11'sd2,   1'b0};
    tbl[4]  = '{most_neg,   -11'sd1,    most_neg,  11'sd0,    1'b0};
    tbl[5]  = '{73'sd5,     11'sd0,     73'sd0,    11'sd0,    1'b1};
    tbl[6]  = '{73'sd9,     11'sd3,     73'sd3,    11'sd0,    1'b0};
    tbl[7]  = '{73'sd0,     11'sd5,     73'sd0,    11'sd0,    1'b0};
    tbl[8]  = '{73'sd1000,  -11'sd1024, 73'sd0,    11'sd1000, 1'b0};
    tbl[9]  = '{~most_neg,  11'sd1,     ~most_neg, 11'sd0,    1'b0};
    tbl[10] = '{-73'sd1023, 11'sd1023,  -73'sd1,   11'sd0,    1'b0};
    tbl[11] = '{73'sd7,     11'sd2,     73'sd3,    11'sd1,    1'b0};
    tbl[12] = '{-73'sd7,    11'sd2,     -73'sd3,   -11'sd1,   1'b0};
    tbl[13] = '{most_neg,   11'sd0,     73'sd0,    11'sd0,    1'b1};

    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1; din0 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_quot", 128'(quot), 128'(0));
    chk("rst_rem", 128'(rem), 128'(0));
    chk("rst_div_zero", 128'(div_zero), 128'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    // Latency of the first operation: out_valid after accept edge + 74.
    send(tbl[0]);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 128'(n), 128'(W0 + 1));
    drain();

    for (int i = 1; i < 14; i++) begin
      send(tbl[i]);
      drain();
    end

    // ce toggling during CALC doubles the latency; then a held-off consumer.
    out_ready = 1'b0;
    send(tbl[2]);
    for (int k = 1; k <= 2 * (W0 + 1); k++) begin
      ce = (k % 2 == 0);
      @(posedge clk); #1;
      if (k == 2 * (W0 + 1) - 1) chk("ce_early_valid", 128'(out_valid), 128'(0));
      if (in_ready) chk("ce_busy_in_ready", 128'(in_ready), 128'(0));
    end
    ce = 1'b1;
    chk("ce_latency_valid", 128'(out_valid), 128'(1));
    q_hold = quot;
    r_hold = rem;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 9 || !out_valid || quot !== q_hold || rem !== r_hold || in_ready) begin
        chk("hold_valid", 128'(out_valid), 128'(1));
        chk("hold_quot", 128'(quot), 128'(q_hold));
        chk("hold_rem", 128'(rem), 128'(r_hold));
        chk("hold_in_ready", 128'(in_ready), 128'(0));
      end
    end
    out_ready = 1'b1;
    drain();

    // Reset mid-calculation aborts the operation without a result.
    send(tbl[0]);
    repeat (29) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    send(tbl[6]);
    drain();

    specials[0] = 11'sd1; specials[1] = -11'sd1; specials[2] = 11'sd1023;
    specials[3] = -11'sd1023; specials[4] = -11'sd1024;
    for (int i = 0; i < 400; i++) begin
      logic [95:0]   r96;
      logic [W0-1:0] a;
      logic [W1-1:0] b;
      r96 = {$urandom, $urandom, $urandom};
      a = r96[W0-1:0];
      if (i % 4 == 1) a = W0'($signed(r96[15:0]));
      b = W1'($urandom);
      if (i % 8 == 3) b = specials[$urandom_range(0, 4)];
      if (i % 50 == 7) a = most_neg;
      v = model(a, b);
      send(v);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
